// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: default widths and FSM states.
package mem_stage_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int PC_W_DEF   = 64;
  localparam int RD_W_DEF   = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: loads the retiring instruction or inserts a bubble.
module mem_wb_reg
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_W   = RD_W_DEF
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              load,
  input  logic              regwrite,
  input  logic              memtoreg,
  input  logic [DATA_W-1:0] aluout,
  input  logic [DATA_W-1:0] rdata,
  input  logic [RD_W-1:0]   rd,
  output logic              mem_wb_regwrite,
  output logic              mem_wb_memtoreg,
  output logic [DATA_W-1:0] mem_wb_aluout,
  output logic [DATA_W-1:0] mem_wb_rdata,
  output logic [RD_W-1:0]   mem_wb_rd
);

  // MEM -> WB boundary: a bubble kills the control bits and leaves data untouched
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      mem_wb_regwrite <= 1'b0;
      mem_wb_memtoreg <= 1'b0;
      mem_wb_aluout   <= '0;
      mem_wb_rdata    <= '0;
      mem_wb_rd       <= '0;
    end else if (load) begin
      mem_wb_regwrite <= regwrite;
      mem_wb_memtoreg <= memtoreg;
      mem_wb_aluout   <= aluout;
      mem_wb_rdata    <= rdata;
      mem_wb_rd       <= rd;
    end else begin
      mem_wb_regwrite <= 1'b0;
      mem_wb_memtoreg <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM stage controller: stalls the front of the pipe around each data-memory
// access, drives the memory request, and feeds the MEM/WB register.
module mem_stage_ctrl
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int PC_W   = PC_W_DEF,
  parameter int RD_W   = RD_W_DEF
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic [DATA_W-1:0] ex_mem_aluout,
  input  logic [DATA_W-1:0] ex_mem_dreg2,
  input  logic [RD_W-1:0]   ex_mem_inst2,
  input  logic              ex_mem_writeback1,
  input  logic              ex_mem_writeback2,
  input  logic              ex_mem_memwrite,
  input  logic              ex_mem_memread,
  input  logic              ex_mem_membranch,
  input  logic              ex_mem_zero,
  input  logic [PC_W-1:0]   ex_mem_branchpc,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              pipe_en,
  output logic              pcsrc,
  output logic [PC_W-1:0]   branch_target,
  output logic              mem_wb_regwrite,
  output logic              mem_wb_memtoreg,
  output logic [DATA_W-1:0] mem_wb_rdata,
  output logic [DATA_W-1:0] mem_wb_aluout,
  output logic [RD_W-1:0]   mem_wb_rd,
  output logic [15:0]       stall_cnt
);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t            state;
  state_t            state_nxt;
  logic              access;
  logic              start_req;
  logic              capture;
  logic [DATA_W-1:0] rdata_cap;
  logic [DATA_W-1:0] wb_rdata;

  assign access        = ex_mem_memread | ex_mem_memwrite;
  assign pcsrc         = ex_mem_membranch & ex_mem_zero & (state == IDLE);
  assign branch_target = ex_mem_branchpc;
  assign wb_rdata      = (state == DONE) ? rdata_cap : '0;

  // FSM state register
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next state, pipeline enable and memory-port strobes
  always_comb begin
    state_nxt = state;
    pipe_en   = 1'b1;
    start_req = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        pipe_en = ~access;
        if (access) begin
          start_req = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        pipe_en = 1'b0;
        if (dmem_ack) begin
          capture   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Memory port registers; a read-and-write op is treated as a write returning 0
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      rdata_cap  <= '0;
    end else if (start_req) begin
      dmem_req   <= 1'b1;
      dmem_we    <= ex_mem_memwrite;
      dmem_addr  <= ex_mem_aluout;
      dmem_wdata <= ex_mem_dreg2;
    end else if (capture) begin
      dmem_req  <= 1'b0;
      rdata_cap <= dmem_we ? '0 : dmem_rdata;
    end
  end

  // Count every edge on which the front of the pipe is held
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n)      stall_cnt <= '0;
    else if (!pipe_en) stall_cnt <= sat_inc16(stall_cnt);
  end

  mem_wb_reg #(
    .DATA_W (DATA_W),
    .RD_W   (RD_W)
  ) u_mem_wb (
    .clk             (clk),
    .arst_n          (arst_n),
    .load            (pipe_en),
    .regwrite        (ex_mem_writeback1),
    .memtoreg        (ex_mem_writeback2),
    .aluout          (ex_mem_aluout),
    .rdata           (wb_rdata),
    .rd              (ex_mem_inst2),
    .mem_wb_regwrite (mem_wb_regwrite),
    .mem_wb_memtoreg (mem_wb_memtoreg),
    .mem_wb_aluout   (mem_wb_aluout),
    .mem_wb_rdata    (mem_wb_rdata),
    .mem_wb_rd       (mem_wb_rd)
  );

endmodule

// File: doc/mem_stage_ctrl.md
MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 Parameters SHALL be: DATA_W, default 32, data/address width; PC_W, default 64, branch target width; RD_W, default 5, destination register index width.
REQ-002 The block SHALL use one clock; reset SHALL be asynchronous and active-low; ports SHALL be, one per line:
  clk  in  1  rising-edge clock
  arst_n  in  1  asynchronous active-low reset
  ex_mem_aluout  in  DATA_W  ALU result / memory address
  ex_mem_dreg2  in  DATA_W  store data
  ex_mem_inst2  in  RD_W  destination register
  ex_mem_writeback1  in  1  RegWrite
  ex_mem_writeback2  in  1  MemtoReg
  ex_mem_memwrite  in  1  store
  ex_mem_memread  in  1  load
  ex_mem_membranch  in  1  branch
  ex_mem_zero  in  1  ALU zero
  ex_mem_branchpc  in  PC_W  branch target
  dmem_req  out  1  memory request, registered
  dmem_we  out  1  write strobe, registered
  dmem_addr  out  DATA_W  address, registered
  dmem_wdata  out  DATA_W  write data, registered
  dmem_ack  in  1  memory completion, single-cycle pulse
  dmem_rdata  in  DATA_W  read data, valid with dmem_ack
  pipe_en  out  1  enable for IF/ID, ID/EX, EX/MEM registers
  pcsrc  out  1  branch taken
  branch_target  out  PC_W  branch target
  mem_wb_regwrite, mem_wb_memtoreg  out  1 each  MEM/WB control
  mem_wb_rdata, mem_wb_aluout  out  DATA_W each  MEM/WB data
  mem_wb_rd  out  RD_W  MEM/WB destination
  stall_cnt  out  16  stall-cycle counter

Function
REQ-003 access SHALL equal ex_mem_memread OR ex_mem_memwrite; the FSM states SHALL be IDLE, REQ, DONE.
REQ-004 IDLE: pipe_en = NOT access; on access, the block SHALL load dmem_addr=aluout, dmem_wdata=dreg2, dmem_we=memwrite, set dmem_req=1, and go to REQ.
REQ-005 REQ: pipe_en=0; dmem_req and dmem_* SHALL be held stable; on dmem_ack the block SHALL capture dmem_rdata (loads only), clear dmem_req on the same edge, and go to DONE; ack wait is unbounded.
REQ-006 DONE: pipe_en=1 for exactly one cycle; the next state SHALL be IDLE unconditionally, and access is not sampled in DONE.
REQ-007 Minimum memory-op stall SHALL be 2 cycles (IDLE-detect, REQ with ack), so each memory op occupies ≥3 cycles in EX/MEM.
REQ-008 If memread and memwrite are both 1, the block SHALL perform a write only; captured rdata SHALL be 0.
REQ-009 dmem_ack outside REQ SHALL be ignored.
REQ-010 On each edge with pipe_en=1, MEM/WB SHALL load regwrite=writeback1, memtoreg=writeback2, aluout, rd=inst2, and rdata = captured data if in DONE, else 0.
REQ-011 On each edge with pipe_en=0, MEM/WB SHALL load a bubble: regwrite=0, memtoreg=0; data fields hold.
REQ-012 pcsrc SHALL be combinational: membranch AND zero AND state==IDLE; branch_target = ex_mem_branchpc.
REQ-013 stall_cnt SHALL increment on each edge with pipe_en=0 and saturate at 0xFFFF.
REQ-014 dmem_addr SHALL pass through unaltered; alignment is not checked.

Reset
REQ-015 arst_n low SHALL immediately force state=IDLE, dmem_req=0, dmem_we=0, and all registered outputs and the captured data to 0.
REQ-016 Reset in REQ SHALL abort the transaction; a late dmem_ack after reset release SHALL be ignored per REQ-009.
REQ-017 With EX/MEM outputs at 0 during reset, pipe_en SHALL read 1 and pcsrc 0.

Structure
REQ-018 A shared package mem_stage_pkg SHALL hold the state enum (IDLE/REQ/DONE) and the DATA_W/PC_W/RD_W defaults.
REQ-019 The MEM/WB register SHALL be one sub-module, mem_wb_reg, with its bubble/load control driven by the FSM.

Verification
REQ-020 Non-memory ALU op, aluout=0x10, rd=3, writeback1=1 -> pipe_en stays 1; next edge mem_wb_aluout=0x10, mem_wb_rd=3, regwrite=1.
REQ-021 Load, addr 0x40, ack in first REQ cycle with rdata=0xDEADBEEF -> pipe_en low 2 cycles; mem_wb_rdata=0xDEADBEEF after DONE; stall_cnt=2.
REQ-022 Store, addr 0x80, wdata 0x1234, ack after 5 REQ cycles -> dmem_we=1 and dmem_addr/wdata stable throughout; pipe_en low 6 cycles; bubbles loaded into MEM/WB.
REQ-023 Branch, membranch=1, zero=1, branchpc=0x200 -> pcsrc=1 and branch_target=0x200 that cycle; with zero=0 -> pcsrc=0.
REQ-024 arst_n pulsed low during REQ, then ack 1 cycle after release -> dmem_req=0 immediately; ack ignored; all outputs 0; FSM IDLE.
REQ-025 stall_cnt preset near saturation by 70000 stall cycles -> stall_cnt holds at 0xFFFF.
